// File: rtl/rtl_settings_pkg.sv
// Shared sizing, mode encodings and address helpers for the traffic test sequencer.
// Pure definitions: no latency, no flow control.
package rtl_settings_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_B_W    = 4;
    localparam     ADDR_TYPE   = "BYTE";
    localparam int AMM_BURST_W = 4;

    typedef enum logic [1:0] {
        WRITE_ONLY      = 2'd0,
        READ_ONLY       = 2'd1,
        WRITE_AND_CHECK = 2'd2
    } test_mode_t;

    typedef enum logic [1:0] {
        FIX = 2'd0,
        RUN = 2'd1,
        RND = 2'd2
    } addr_mode_t;

    // Galois feedback mask for taps 32,22,2,1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

    function automatic logic [ADDR_W-1:0] calc_step(input logic [AMM_BURST_W-2:0] burst);
        logic [ADDR_W-1:0] beats;
        beats = ADDR_W'(burst) + ADDR_W'(1);
        if (ADDR_TYPE == "BYTE")
            return beats * ADDR_W'(DATA_B_W);
        else
            return beats;
    endfunction

endpackage

// File: rtl/addr_gen.sv
// Per-transaction address source: fixed, running (base + n*step, wrapping) or LFSR.
// Address is valid the cycle after load; advance moves it by one transaction.
module addr_gen
    import rtl_settings_pkg::*;
#(
    parameter logic [31:0] RND_SEED = 32'h0000_0001
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load,
    input  logic                   advance,
    input  addr_mode_t             mode,
    input  logic [ADDR_W-1:0]      base,
    input  logic [AMM_BURST_W-2:0] burst,
    output logic [ADDR_W-1:0]      addr
);

    addr_mode_t        mode_r;
    logic [ADDR_W-1:0] run_addr;
    logic [ADDR_W-1:0] step;
    logic [31:0]       lfsr;

    // The LFSR is only reseeded by reset so successive random tests keep walking the sequence
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_r   <= FIX;
            run_addr <= '0;
            step     <= '0;
            lfsr     <= RND_SEED;
        end else if (load) begin
            mode_r   <= mode;
            run_addr <= base;
            step     <= calc_step(burst);
        end else if (advance) begin
            if (mode_r == RUN)
                run_addr <= run_addr + step;
            if (mode_r == RND)
                lfsr <= lfsr_next(lfsr);
        end
    end

    assign addr = (mode_r == RND) ? lfsr[ADDR_W-1:0] : run_addr;

endmodule

// File: rtl/test_sequencer.sv
// Issues one-at-a-time read/write requests to a transmitter and tracks test status.
// A request goes out only while trans_busy is low; each then waits for busy to drop.
module test_sequencer
    import rtl_settings_pkg::*;
#(
    parameter logic [31:0] RND_SEED      = 32'h0000_0001,
    parameter int          STALL_TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0][31:0]  test_param_i,
    input  logic              trans_busy_i,
    input  logic              cmp_error_i,
    output logic              trans_valid_o,
    output logic [ADDR_W-1:0] trans_addr_o,
    output logic              trans_type_o,
    output logic              test_busy_o,
    output logic              test_done_o,
    output logic              test_error_o,
    output logic              timeout_o,
    output logic [31:0]       trans_cnt_o
);

    localparam int TMR_W = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [31:0]       count_r;
    logic [31:0]       done_tx;
    test_mode_t        mode_r;
    logic              read_next;
    logic [TMR_W-1:0]  timer;
    test_mode_t        tm_in;
    addr_mode_t        am_in;
    logic [ADDR_W-1:0] gen_addr;
    logic              accept, do_issue, set_to, stall, abort;
    logic              is_read, advance;
    logic              unused_param;

    always_comb begin
        case (test_param_i[1][17:16])
            2'd1:    tm_in = READ_ONLY;
            2'd2:    tm_in = WRITE_AND_CHECK;
            default: tm_in = WRITE_ONLY;
        endcase
        case (test_param_i[1][19:18])
            2'd1:    am_in = RUN;
            2'd2:    am_in = RND;
            default: am_in = FIX;
        endcase
    end

    assign unused_param = ^{test_param_i[3], test_param_i[1][31:20],
                            test_param_i[1][15:AMM_BURST_W-1], test_param_i[2][31:ADDR_W]};

    // A write-and-check pair only counts (and moves the address) once its read is issued
    assign is_read = (mode_r == READ_ONLY) || ((mode_r == WRITE_AND_CHECK) && read_next);
    assign advance = do_issue && !((mode_r == WRITE_AND_CHECK) && !read_next);
    assign stall   = trans_busy_i && (timer == TMR_W'(STALL_TIMEOUT - 1));
    assign abort   = cmp_error_i || test_error_o;

    addr_gen #(.RND_SEED(RND_SEED)) u_addr_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (accept),
        .advance (advance),
        .mode    (am_in),
        .base    (test_param_i[2][ADDR_W-1:0]),
        .burst   (test_param_i[1][AMM_BURST_W-2:0]),
        .addr    (gen_addr)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_issue  = 1'b0;
        set_to    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    accept    = 1'b1;
                    state_nxt = (test_param_i[0] != 32'd0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (stall) begin
                    set_to    = 1'b1;
                    state_nxt = DONE;
                end else if (abort) begin
                    if (!trans_busy_i)
                        state_nxt = DONE;
                end else if (!trans_busy_i) begin
                    do_issue  = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: state_nxt = WAIT;
            WAIT: begin
                if (stall) begin
                    set_to    = 1'b1;
                    state_nxt = DONE;
                end else if (!trans_busy_i) begin
                    state_nxt = (!abort && (done_tx < count_r)) ? ISSUE : DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_r       <= '0;
            done_tx       <= '0;
            mode_r        <= WRITE_ONLY;
            read_next     <= 1'b0;
            timer         <= '0;
            trans_valid_o <= 1'b0;
            trans_addr_o  <= '0;
            trans_type_o  <= 1'b0;
            trans_cnt_o   <= '0;
            test_error_o  <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            trans_valid_o <= do_issue;
            if ((state == ISSUE || state == WAIT) && trans_busy_i)
                timer <= timer + TMR_W'(1);
            else
                timer <= '0;
            if (accept) begin
                count_r      <= test_param_i[0];
                mode_r       <= tm_in;
                done_tx      <= '0;
                read_next    <= 1'b0;
                trans_cnt_o  <= '0;
                test_error_o <= 1'b0;
                timeout_o    <= 1'b0;
            end
            if (do_issue) begin
                trans_addr_o <= gen_addr;
                trans_type_o <= is_read;
                trans_cnt_o  <= trans_cnt_o + 32'd1;
                if (mode_r == WRITE_AND_CHECK)
                    read_next <= !read_next;
                if (advance)
                    done_tx <= done_tx + 32'd1;
            end
            if (cmp_error_i && state != IDLE)
                test_error_o <= 1'b1;
            if (set_to)
                timeout_o <= 1'b1;
        end
    end

    assign test_busy_o = (state != IDLE);
    assign test_done_o = (state == DONE);

endmodule
